// File: rtl/axi_frontend_loader.sv
`default_nettype none
// ============================================================================
// Module   : axi_frontend_loader
// Purpose  : AXI4 write initiator for the NutShell frontend slave port.
//            Turns a host command (start address + word count) and a word
//            stream into INCR write bursts into guest memory. Bursts never
//            cross a 4 KB page and only one burst is in flight at a time.
//            Used to preload program images and to inject data at run time.
// Ports    : clk, rst (sync, active-low)
//            cmd_valid/cmd_ready/cmd_addr/cmd_len - command channel
//            s_valid/s_ready/s_data               - word stream in
//            busy/done/error                      - status
//            m_axi_aw* / m_axi_w* / m_axi_b*      - AXI4 write master
// Revision : 1.0 - initial release
// ============================================================================
module axi_frontend_loader #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 64,
   parameter int          ID_WIDTH   = 1,
   parameter int unsigned AXI_ID     = 0,
   parameter int          MAX_BURST  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   // command channel
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [31:0]             cmd_len,
   // data stream
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_data,
   // status
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   // AXI write address channel
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   // AXI write data channel
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   // AXI write response channel
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   input  logic [ID_WIDTH-1:0]     m_axi_bid
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   // Beats for the next burst: limited by words left, MAX_BURST and the
   // distance to the next 4 KB page boundary. Only the page offset of the
   // address matters. Result is 1..256 whenever rem != 0.
   function automatic logic [8:0] calc_beats(input logic [11:0] a_lo,
                                             input logic [31:0] rem);
      logic [12:0] to_page;
      logic [12:0] page_beats;
      logic [31:0] b;
      to_page    = 13'd4096 - {1'b0, a_lo};
      page_beats = to_page >> SIZE;
      b          = rem;
      if (b > 32'(MAX_BURST)) begin
         b = 32'(MAX_BURST);
      end
      if (b > {19'd0, page_beats}) begin
         b = {19'd0, page_beats};
      end
      return b[8:0];
   endfunction

   state_t                 state_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [31:0]            rem_q;
   logic [8:0]             beats_q;
   logic [7:0]             awlen_q;
   logic [7:0]             beat_q;
   logic                   awvalid_q;
   logic                   bready_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   error_q;

   logic [ADDR_WIDTH-1:0]  cmd_addr_al;
   logic [8:0]             cmd_beats_d;
   logic [8:0]             next_beats_d;
   logic                   w_hs;
   logic                   last_beat;

   // Word-align the command address by dropping the byte-lane bits.
   assign cmd_addr_al  = {cmd_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
   assign cmd_beats_d  = calc_beats(cmd_addr_al[11:0], cmd_len);
   // Sized from the already-advanced address/remaining while in B.
   assign next_beats_d = calc_beats(addr_q[11:0], rem_q);

   // Write data is a straight pass-through of the stream; no buffering.
   assign m_axi_wvalid = (state_q == S_W) && s_valid;
   assign s_ready      = (state_q == S_W) && m_axi_wready;
   assign m_axi_wdata  = s_data;
   assign m_axi_wstrb  = '1;
   assign last_beat    = (beat_q == awlen_q);
   assign m_axi_wlast  = (state_q == S_W) && last_beat;
   assign w_hs         = m_axi_wvalid && m_axi_wready;

   assign cmd_ready     = (state_q == S_IDLE);
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;

   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awid    = ID_WIDTH'(AXI_ID);
   assign m_axi_awlen   = awlen_q;
   assign m_axi_awsize  = 3'(SIZE);
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd0;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_bready  = bready_q;

   // The response ID and the byte-lane address bits carry no information.
   logic unused_inputs;
   assign unused_inputs = ^{m_axi_bid, cmd_addr[SIZE-1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         beats_q   <= '0;
         awlen_q   <= '0;
         beat_q    <= '0;
         awvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr_al;
                  rem_q   <= cmd_len;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (cmd_len == 32'd0) begin
                     state_q <= S_FIN;
                  end else begin
                     beats_q   <= cmd_beats_d;
                     // beats of 256 wraps to 0 in 8 bits, giving awlen 255
                     awlen_q   <= cmd_beats_d[7:0] - 8'd1;
                     awvalid_q <= 1'b1;
                     state_q   <= S_AW;
                  end
               end
            end
            S_AW: begin
               if (m_axi_awready) begin
                  awvalid_q <= 1'b0;
                  beat_q    <= 8'd0;
                  state_q   <= S_W;
               end
            end
            S_W: begin
               if (w_hs) begin
                  beat_q <= beat_q + 8'd1;
                  if (last_beat) begin
                     rem_q    <= rem_q - {23'd0, beats_q};
                     addr_q   <= addr_q + ({{(ADDR_WIDTH-9){1'b0}}, beats_q} << SIZE);
                     bready_q <= 1'b1;
                     state_q  <= S_B;
                  end
               end
            end
            S_B: begin
               if (m_axi_bvalid) begin
                  bready_q <= 1'b0;
                  if (m_axi_bresp != 2'b00) begin
                     error_q <= 1'b1;
                  end
                  if (rem_q != 32'd0) begin
                     beats_q   <= next_beats_d;
                     awlen_q   <= next_beats_d[7:0] - 8'd1;
                     awvalid_q <= 1'b1;
                     state_q   <= S_AW;
                  end else begin
                     state_q <= S_FIN;
                  end
               end
            end
            S_FIN: begin
               // First FIN cycle raises done; the second returns to IDLE,
               // so busy drops and cmd_ready rises right after the pulse.
               if (!done_q) begin
                  done_q <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_frontend_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_frontend_loader
// Purpose  : Directed self-checking bench for axi_frontend_loader with a
//            simple AXI write slave and a word-stream source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_frontend_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_len = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [63:0] s_data = '0;
   logic        busy, done, error;
   logic        m_axi_awvalid;
   logic        m_axi_awready = 1'b0;
   logic [31:0] m_axi_awaddr;
   logic [0:0]  m_axi_awid;
   logic [7:0]  m_axi_awlen;
   logic [2:0]  m_axi_awsize;
   logic [1:0]  m_axi_awburst;
   logic        m_axi_awlock;
   logic [3:0]  m_axi_awcache;
   logic [2:0]  m_axi_awprot;
   logic [3:0]  m_axi_awqos;
   logic        m_axi_wvalid;
   logic        m_axi_wready = 1'b0;
   logic [63:0] m_axi_wdata;
   logic [7:0]  m_axi_wstrb;
   logic        m_axi_wlast;
   logic        m_axi_bvalid = 1'b0;
   logic        m_axi_bready;
   logic [1:0]  m_axi_bresp = 2'b00;
   logic [0:0]  m_axi_bid = 1'b0;

   axi_frontend_loader #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(1), .AXI_ID(0), .MAX_BURST(16)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .busy(busy), .done(done), .error(error),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bid(m_axi_bid)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // stimulus / slave configuration
   bit          rand_aw = 1'b0, rand_w = 1'b0, rand_s = 1'b0;
   int          err_burst = -1;
   logic [63:0] src [0:63];
   int          src_n = 0, src_idx = 0;

   // observation logs and reference state
   logic [31:0] aw_addr_log[$];
   logic [7:0]  aw_len_log[$];
   logic [63:0] w_data_log[$];
   bit          w_last_log[$];
   int          b_cnt = 0, wl_cnt = 0, done_cnt = 0;
   bit          w_phase = 1'b0, err_m = 1'b0, aw_wait = 1'b0;
   logic [31:0] aw_prev_addr = '0;
   logic [7:0]  aw_prev_len = '0;

   // expected bursts for the current test
   logic [31:0] exp_addr [0:3];
   logic [7:0]  exp_len  [0:3];

   // Slave and source driver: updates just after each rising edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         m_axi_awready = rand_aw ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axi_wready  = rand_w  ? 1'($urandom_range(0, 1)) : 1'b1;
         if (src_idx < src_n) begin
            s_valid = rand_s ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = src[src_idx];
         end else begin
            s_valid = 1'b0;
            s_data  = '0;
         end
         m_axi_bvalid = (wl_cnt > b_cnt);
         m_axi_bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      end
   end

   // Monitor: samples mid-cycle, checks per-cycle rules, logs handshakes.
   initial begin
      forever begin
         @(negedge clk);
         check("error_flag", error, err_m);
         check("wvalid_passthru", m_axi_wvalid, s_valid & w_phase);
         check("s_ready_gate", s_ready, w_phase & m_axi_wready);
         if (aw_wait) begin
            check("awvalid_hold", m_axi_awvalid, 1'b1);
            check("awaddr_hold", m_axi_awaddr, aw_prev_addr);
            check("awlen_hold", m_axi_awlen, aw_prev_len);
         end
         if (!rst) begin
            w_phase = 1'b0;
            err_m   = 1'b0;
            aw_wait = 1'b0;
         end else begin
            aw_wait      = m_axi_awvalid && !m_axi_awready;
            aw_prev_addr = m_axi_awaddr;
            aw_prev_len  = m_axi_awlen;
            if (cmd_valid && cmd_ready) err_m = 1'b0;
            if (m_axi_bvalid && m_axi_bready) begin
               b_cnt++;
               if (m_axi_bresp != 2'b00) err_m = 1'b1;
            end
            if (m_axi_awvalid && m_axi_awready) begin
               aw_addr_log.push_back(m_axi_awaddr);
               aw_len_log.push_back(m_axi_awlen);
               w_phase = 1'b1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
               w_data_log.push_back(m_axi_wdata);
               w_last_log.push_back(m_axi_wlast);
               if (m_axi_wlast) begin
                  wl_cnt++;
                  w_phase = 1'b0;
               end
            end
            if (s_valid && s_ready) src_idx++;
            if (done) done_cnt++;
         end
      end
   end

   task automatic prep(input int t, input int n);
      @(posedge clk); #2;
      for (int i = 0; i < 64; i++) src[i] = {16'hC0DE, 16'(t), 32'(i)};
      src_n   = n;
      src_idx = 0;
      aw_addr_log.delete();
      aw_len_log.delete();
      w_data_log.delete();
      w_last_log.delete();
      b_cnt    = 0;
      wl_cnt   = 0;
      done_cnt = 0;
   endtask

   task automatic issue_cmd(input logic [31:0] a, input logic [31:0] l);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("cmd_ready_wait", cmd_ready, 1'b1);
      @(posedge clk); #2;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
   endtask

   // Issues a command and returns the cycle count from accept to done.
   task automatic run_cmd(input logic [31:0] a, input logic [31:0] l, output int lat);
      issue_cmd(a, l);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) check("busy_on_accept", busy, 1'b1);
      end while (!done && lat < 3000);
      check("done_seen", done, 1'b1);
      check("busy_at_done", busy, 1'b1);
      check("cmd_ready_at_done", cmd_ready, 1'b0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      check("cmd_ready_after_done", cmd_ready, 1'b1);
   endtask

   task automatic verify(input string t, input int nbeats, input int naw);
      bit exp_last [0:63];
      int pos;
      for (int i = 0; i < 64; i++) exp_last[i] = 1'b0;
      pos = 0;
      for (int k = 0; k < naw; k++) begin
         pos = pos + int'(exp_len[k]) + 1;
         if (pos >= 1 && pos <= 64) exp_last[pos-1] = 1'b1;
      end
      check($sformatf("%s_aw_count", t), aw_addr_log.size(), naw);
      for (int k = 0; k < naw && k < aw_addr_log.size(); k++) begin
         check($sformatf("%s_awaddr%0d", t, k), aw_addr_log[k], exp_addr[k]);
         check($sformatf("%s_awlen%0d", t, k), aw_len_log[k], exp_len[k]);
      end
      check($sformatf("%s_w_count", t), w_data_log.size(), nbeats);
      for (int i = 0; i < nbeats && i < w_data_log.size(); i++) begin
         check($sformatf("%s_wdata%0d", t, i), w_data_log[i], src[i]);
         check($sformatf("%s_wlast%0d", t, i), w_last_log[i], exp_last[i]);
      end
      check($sformatf("%s_b_count", t), b_cnt, naw);
      check($sformatf("%s_done_count", t), done_cnt, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int guard;
      // reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awvalid", m_axi_awvalid, 1'b0);
      check("rst_wvalid", m_axi_wvalid, 1'b0);
      check("rst_bready", m_axi_bready, 1'b0);
      check("rst_s_ready", s_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #2;
      rst = 1'b1;

      // T1: single 4-beat burst
      prep(1, 4);
      exp_addr[0] = 32'h8000_0000; exp_len[0] = 8'd3;
      run_cmd(32'h8000_0000, 32'd4, lat);
      verify("t1", 4, 1);
      check("t1_latency", lat, 8);
      check("t1_error", error, 1'b0);
      check("awsize", m_axi_awsize, 3'd3);
      check("awburst", m_axi_awburst, 2'b01);
      check("awid", m_axi_awid, 1'b0);
      check("wstrb", m_axi_wstrb, 8'hFF);
      check("aw_misc_zero", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}, 12'd0);

      // T2: 40 words split into MAX_BURST chunks
      prep(2, 40);
      exp_addr[0] = 32'h0;   exp_len[0] = 8'd15;
      exp_addr[1] = 32'h80;  exp_len[1] = 8'd15;
      exp_addr[2] = 32'h100; exp_len[2] = 8'd7;
      run_cmd(32'h0, 32'd40, lat);
      verify("t2", 40, 3);

      // T3: 4 KB boundary split
      prep(3, 4);
      exp_addr[0] = 32'hFF0;  exp_len[0] = 8'd1;
      exp_addr[1] = 32'h1000; exp_len[1] = 8'd1;
      run_cmd(32'hFF0, 32'd4, lat);
      verify("t3", 4, 2);

      // T4: random stalls on stream, W and AW
      prep(4, 20);
      rand_aw = 1'b1; rand_w = 1'b1; rand_s = 1'b1;
      exp_addr[0] = 32'h2000; exp_len[0] = 8'd15;
      exp_addr[1] = 32'h2080; exp_len[1] = 8'd3;
      run_cmd(32'h2000, 32'd20, lat);
      rand_aw = 1'b0; rand_w = 1'b0; rand_s = 1'b0;
      verify("t4", 20, 2);

      // T5: SLVERR on the second burst, then cleared by a new command
      prep(5, 32);
      err_burst = 1;
      exp_addr[0] = 32'h3000; exp_len[0] = 8'd15;
      exp_addr[1] = 32'h3080; exp_len[1] = 8'd15;
      run_cmd(32'h3000, 32'd32, lat);
      verify("t5", 32, 2);
      check("t5_error_set", error, 1'b1);
      err_burst = -1;
      prep(8, 1);
      exp_addr[0] = 32'h4000; exp_len[0] = 8'd0;
      run_cmd(32'h4007, 32'd1, lat);
      verify("t5b", 1, 1);
      check("t5b_error_clear", error, 1'b0);
      check("t5b_single_latency", lat, 5);

      // T6: reset in the middle of a W burst, then a zero-length command
      prep(6, 16);
      issue_cmd(32'h5000, 32'd16);
      guard = 0;
      while (w_data_log.size() < 5 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("t6_reached_w", (w_data_log.size() >= 5), 1'b1);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t6_awvalid", m_axi_awvalid, 1'b0);
      check("t6_wvalid", m_axi_wvalid, 1'b0);
      check("t6_bready", m_axi_bready, 1'b0);
      check("t6_s_ready", s_ready, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #2;
      rst = 1'b1;
      prep(7, 0);
      run_cmd(32'h6000, 32'd0, lat);
      check("t6_zero_latency", lat, 2);
      check("t6_zero_aw", aw_addr_log.size(), 0);
      check("t6_zero_w", w_data_log.size(), 0);
      check("t6_zero_b", b_cnt, 0);
      check("t6_zero_done", done_cnt, 1);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
